// File: rtl/axis_pkt_fifo_pkg.sv
// Shared definitions for the AXI-Stream packet FIFO: parameter defaults and
// the write-side mode encoding.
package axis_pkt_fifo_pkg;

  localparam int AXIS_PKT_FIFO_DATA_WIDTH = 16;
  localparam int AXIS_PKT_FIFO_ADDR_WIDTH = 8;

  // Write side either stores beats or silently swallows an oversized packet.
  typedef enum logic {
    WR_STORE = 1'b0,
    WR_DROP  = 1'b1
  } wr_mode_e;

endpackage

// File: rtl/axis_skid.sv
// One-entry skid buffer with a registered AXI-Stream output. The output
// register holds its payload while stalled; a second register catches the
// beat already in flight when the stall begins, so s_ready_o is registered
// and throughput stays at one beat per cycle.
module axis_skid #(
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s_data_i,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  output logic [WIDTH-1:0] m_data_o,
  output logic             m_valid_o,
  input  logic             m_ready_i
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             out_free;

  assign out_free  = ~out_valid_q | m_ready_i;
  assign s_ready_o = ~skid_valid_q;
  assign m_valid_o = out_valid_q;
  assign m_data_o  = out_data_q;

  // Next state: refill the output from the skid first, else from the input;
  // park the input beat in the skid when the output is stalled.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (out_free) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = s_valid_i;
        if (s_valid_i) out_data_d = s_data_i;
      end
    end else if (s_valid_i && !skid_valid_q) begin
      skid_valid_d = 1'b1;
      skid_data_d  = s_data_i;
    end
  end

  // Valid flags are reset; payload registers need no reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  // Payload registers.
  always_ff @(posedge clk) begin
    out_data_q  <= out_data_d;
    skid_data_q <= skid_data_d;
  end

endmodule

// File: rtl/axis_pkt_fifo.sv
// Store-and-forward AXI-Stream packet FIFO.
// Handshake: a beat transfers on a rising edge where valid & ready are both
// high; valid never waits on ready, and payload holds while valid & ~ready.
// Beats are written at wr_ptr; the read side only sees data up to commit_ptr,
// which jumps forward when a tlast beat is stored. Storage is released
// (rd_ptr) only when a beat leaves on m_*, while fetch_ptr runs ahead to
// prefetch into the memory read register and the output skid.
module axis_pkt_fifo
  import axis_pkt_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = AXIS_PKT_FIFO_DATA_WIDTH,
  parameter int ADDR_WIDTH = AXIS_PKT_FIFO_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tlast,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tlast,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  drop,
  output logic [ADDR_WIDTH:0]   pkt_count
);

  localparam int              PW      = ADDR_WIDTH + 1;
  localparam int              DEPTH_N = 1 << ADDR_WIDTH;
  localparam logic [PW-1:0]   DEPTH_P = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [PW-1:0]   ONE     = {{ADDR_WIDTH{1'b0}}, 1'b1};

  wr_mode_e        mode_q, mode_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   commit_ptr_q, commit_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   fetch_ptr_q, fetch_ptr_d;
  logic [PW-1:0]   pkt_count_q, pkt_count_d;
  logic            drop_q, drop_d;
  logic            rd_valid_q, rd_valid_d;

  logic [DATA_WIDTH:0] mem_q [DEPTH_N];
  logic [DATA_WIDTH:0] rdata_q;
  logic [DATA_WIDTH:0] out_payload;

  logic full, oversize, dropping, s_fire, wr_en, commit;
  logic empty, skid_in_ready, pop, fetch, m_fire, last_out;

  // The in-progress packet alone occupies every slot: it can never commit.
  assign full     = (wr_ptr_q - rd_ptr_q) == DEPTH_P;
  assign oversize = full && ((wr_ptr_q - commit_ptr_q) == DEPTH_P);

  // Write-mode state register.
  always_ff @(posedge clk) begin
    if (rst) mode_q <= WR_STORE;
    else     mode_q <= mode_d;
  end

  // Write-mode next state: enter drop on an oversized packet, leave on its tlast.
  always_comb begin
    mode_d = mode_q;
    case (mode_q)
      WR_STORE: if (oversize) mode_d = WR_DROP;
      WR_DROP:  if (s_fire && s_tlast) mode_d = WR_STORE;
      default:  mode_d = WR_STORE;
    endcase
  end

  // Write-mode outputs: accept everything while dropping, but store nothing.
  always_comb begin
    dropping = (mode_q == WR_DROP);
    s_tready = ~full | dropping;
    s_fire   = s_tvalid & s_tready;
    wr_en    = s_fire & ~dropping;
    commit   = wr_en & s_tlast;
  end

  // Read-side control: prefetch committed beats into the read register and
  // let them advance whenever the skid can take them.
  always_comb begin
    empty    = (fetch_ptr_q == commit_ptr_q);
    pop      = rd_valid_q & skid_in_ready;
    fetch    = ~empty & (~rd_valid_q | pop);
    m_fire   = m_tvalid & m_tready;
    last_out = m_fire & m_tlast;
  end

  // Pointer and counter next state.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fetch_ptr_d  = fetch_ptr_q;
    pkt_count_d  = pkt_count_q;
    drop_d       = 1'b0;
    rd_valid_d   = fetch | (rd_valid_q & ~pop);
    if ((mode_q == WR_STORE) && oversize) begin
      wr_ptr_d = commit_ptr_q;
      drop_d   = 1'b1;
    end else if (wr_en) begin
      wr_ptr_d = wr_ptr_q + ONE;
    end
    if (commit) commit_ptr_d = wr_ptr_q + ONE;
    if (fetch)  fetch_ptr_d  = fetch_ptr_q + ONE;
    if (m_fire) rd_ptr_d     = rd_ptr_q + ONE;
    case ({commit, last_out})
      2'b10:   pkt_count_d = pkt_count_q + ONE;
      2'b01:   pkt_count_d = pkt_count_q - ONE;
      default: pkt_count_d = pkt_count_q;
    endcase
  end

  // Control registers; reset discards every stored and partial packet.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      fetch_ptr_q  <= '0;
      pkt_count_q  <= '0;
      drop_q       <= 1'b0;
      rd_valid_q   <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fetch_ptr_q  <= fetch_ptr_d;
      pkt_count_q  <= pkt_count_d;
      drop_q       <= drop_d;
      rd_valid_q   <= rd_valid_d;
    end
  end

  // Simple dual-port storage with a registered, enabled read port.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= {s_tdata, s_tlast};
    if (fetch) rdata_q <= mem_q[fetch_ptr_q[ADDR_WIDTH-1:0]];
  end

  axis_skid #(
    .WIDTH(DATA_WIDTH + 1)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .s_data_i  (rdata_q),
    .s_valid_i (rd_valid_q),
    .s_ready_o (skid_in_ready),
    .m_data_o  (out_payload),
    .m_valid_o (m_tvalid),
    .m_ready_i (m_tready)
  );

  assign m_tdata   = out_payload[DATA_WIDTH:1];
  assign m_tlast   = m_tvalid & out_payload[0];
  assign drop      = drop_q;
  assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Bench for axis_pkt_fifo with ADDR_WIDTH=4 (16 beats). The reference model
// works at packet level: every packet of at most 16 beats comes out intact
// and in order, longer packets vanish, and reset forgets everything.
module tb_axis_pkt_fifo;

  localparam int DW      = 16;
  localparam int AW      = 4;
  localparam int DEPTH   = 16;
  localparam int W       = DW + 1;
  localparam int TIMEOUT = 200;

  // Clock / reset and DUT signals
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] s_tdata = '0;
  logic          s_tlast = 1'b0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tlast;
  logic          m_tvalid;
  logic          m_tready = 1'b1;
  logic          drop;
  logic [AW:0]   pkt_count;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
  int accepted = 0;
  int stall_cnt = 0;
  int drop_cnt = 0;
  int xfer_cnt = 0;
  int first_xfer = 0;
  int last_xfer = 0;
  int max_pkt = 0;
  int cyc = 0;
  int wait_log[64];
  logic prev_stall = 1'b0;
  logic prev_drop = 1'b0;
  logic [W-1:0] prev_beat = '0;

  axis_pkt_fifo #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s_tdata   (s_tdata),
    .s_tlast   (s_tlast),
    .s_tvalid  (s_tvalid),
    .s_tready  (s_tready),
    .m_tdata   (m_tdata),
    .m_tlast   (m_tlast),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready),
    .drop      (drop),
    .pkt_count (pkt_count)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Driver: present one beat, wait (bounded) for s_tready, return wait cycles.
  task automatic send_beat(input logic [DW-1:0] d, input logic l, output int waited);
    bit ok;
    ok = 1'b0;
    waited = 0;
    s_tdata = d;
    s_tlast = l;
    s_tvalid = 1'b1;
    while (1) begin
      @(negedge clk);
      ok = s_tready;
      if (ok || waited >= TIMEOUT) break;
      waited++;
    end
    if (!ok) s_tvalid = 1'b0;
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    check("send_accept", 32'(ok), 32'd1);
    if (ok) accepted++;
  endtask

  // Driver + model: send a packet, then record its beats as expected output
  // unless it is too long to ever fit.
  task automatic send_pkt(input int len, input bit rnd, input logic [DW-1:0] base);
    logic [W-1:0] beats[$];
    int w;
    for (int i = 0; i < len; i++) begin
      logic [DW-1:0] d;
      logic l;
      d = rnd ? DW'($urandom) : base + DW'(i);
      l = (i == len - 1);
      send_beat(d, l, w);
      if (i < 64) wait_log[i] = w;
      stall_cnt += w;
      beats.push_back({d, l});
    end
    if (len <= DEPTH) begin
      foreach (beats[k]) exp_q.push_back(beats[k]);
    end
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_tvalid) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    xfer_cnt = 0;
    drop_cnt = 0;
    stall_cnt = 0;
    max_pkt = 0;
    accepted = 0;
  endtask

  // Scoreboard / monitor, sampled on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      prev_stall = 1'b0;
      prev_drop = 1'b0;
    end else begin
      if (m_tlast) check("tlast_gated", 32'(m_tvalid), 32'd1);
      if (prev_stall) begin
        check("stall_valid", 32'(m_tvalid), 32'd1);
        check("stall_hold", 32'({m_tdata, m_tlast}), 32'(prev_beat));
      end
      if (drop) begin
        drop_cnt++;
        check("drop_single", 32'(prev_drop), 32'd0);
      end
      if (int'(pkt_count) > max_pkt) max_pkt = int'(pkt_count);
      if (m_tvalid && m_tready) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_beat: observed data=0x%0h last=%0d, expected no beat", m_tdata, m_tlast);
        end
        if (exp_q.size() != 0) check("beat", 32'({m_tdata, m_tlast}), 32'(exp_q.pop_front()));
        if (xfer_cnt == 0) first_xfer = cyc;
        last_xfer = cyc;
        xfer_cnt++;
      end
      prev_stall = m_tvalid && !m_tready;
      prev_beat = {m_tdata, m_tlast};
      prev_drop = drop;
    end
  end

  initial begin
    int w;
    int n;

    // Reset state
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    @(negedge clk);
    check("rst_s_tready", 32'(s_tready), 32'd1);
    check("rst_m_tvalid", 32'(m_tvalid), 32'd0);
    check("rst_m_tlast", 32'(m_tlast), 32'd0);
    check("rst_drop", 32'(drop), 32'd0);
    check("rst_pkt_count", 32'(pkt_count), 32'd0);
    idle(1);

    // Store-and-forward 4-beat packet and first-beat latency
    clear_stats();
    m_tready = 1'b1;
    for (int i = 0; i < 3; i++) send_beat(DW'(16'h11 + i), 1'b0, w);
    repeat (4) begin
      @(negedge clk);
      check("sf_hold_tvalid", 32'(m_tvalid), 32'd0);
    end
    idle(1);
    send_beat(16'h14, 1'b1, w);
    exp_q.push_back({16'h11, 1'b0});
    exp_q.push_back({16'h12, 1'b0});
    exp_q.push_back({16'h13, 1'b0});
    exp_q.push_back({16'h14, 1'b1});
    @(negedge clk);
    check("lat_tvalid_c1", 32'(m_tvalid), 32'd0);
    check("lat_pkt_count", 32'(pkt_count), 32'd1);
    @(negedge clk);
    check("lat_tvalid_c2", 32'(m_tvalid), 32'd0);
    @(negedge clk);
    check("lat_tvalid_c3", 32'(m_tvalid), 32'd1);
    check("lat_tdata_c3", 32'(m_tdata), 32'h11);
    wait_drain("sf_drain");
    check("sf_xfers", 32'(xfer_cnt), 32'd4);
    check("sf_consecutive", 32'(last_xfer - first_xfer), 32'd3);
    check("sf_pkt_count_end", 32'(pkt_count), 32'd0);

    // Oversized 20-beat packet is dropped, next packet intact
    clear_stats();
    send_pkt(20, 1'b1, '0);
    idle(4);
    check("ovr_drop_cnt", 32'(drop_cnt), 32'd1);
    check("ovr_pkt_count", 32'(pkt_count), 32'd0);
    check("ovr_m_tvalid", 32'(m_tvalid), 32'd0);
    check("ovr_accepted", 32'(accepted), 32'd20);
    for (int i = 17; i < 20; i++) check("ovr_ready_tail", 32'(wait_log[i]), 32'd0);
    send_pkt(2, 1'b0, 16'h0A0);
    wait_drain("ovr_next_drain");
    check("ovr_next_xfers", 32'(xfer_cnt), 32'd2);

    // Back-pressure: three 5-beat packets plus a fourth, m_tready low
    clear_stats();
    m_tready = 1'b0;
    fork
      begin
        for (int p = 0; p < 4; p++) send_pkt(5, 1'b0, 16'(16'h100 + p * 16));
      end
      begin
        repeat (40) @(negedge clk);
        check("bp_accepted", 32'(accepted), 32'd16);
        check("bp_s_tready", 32'(s_tready), 32'd0);
        check("bp_pkt_count", 32'(pkt_count), 32'd3);
        check("bp_m_tvalid", 32'(m_tvalid), 32'd1);
        check("bp_m_tdata", 32'(m_tdata), 32'h100);
        @(posedge clk);
        #1;
        m_tready = 1'b1;
      end
    join
    wait_drain("bp_drain");
    check("bp_accepted_all", 32'(accepted), 32'd20);
    check("bp_xfers", 32'(xfer_cnt), 32'd20);
    check("bp_pkt_count_end", 32'(pkt_count), 32'd0);

    // Random stalls during a 6-beat readout
    clear_stats();
    m_tready = 1'b0;
    send_pkt(6, 1'b1, '0);
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      m_tready = 1'($urandom_range(0, 1));
      idle(1);
      n++;
    end
    m_tready = 1'b1;
    wait_drain("stall_drain");
    check("stall_xfers", 32'(xfer_cnt), 32'd6);

    // Reset mid-packet with a committed packet stored
    clear_stats();
    m_tready = 1'b0;
    send_pkt(3, 1'b0, 16'h300);
    send_beat(16'h400, 1'b0, w);
    send_beat(16'h401, 1'b0, w);
    rst = 1'b1;
    exp_q.delete();
    idle(2);
    rst = 1'b0;
    @(negedge clk);
    check("mrst_m_tvalid", 32'(m_tvalid), 32'd0);
    check("mrst_pkt_count", 32'(pkt_count), 32'd0);
    check("mrst_s_tready", 32'(s_tready), 32'd1);
    idle(1);
    m_tready = 1'b1;
    idle(5);
    check("mrst_stays_empty", 32'(m_tvalid), 32'd0);
    send_pkt(3, 1'b0, 16'h500);
    wait_drain("mrst_new_drain");
    check("mrst_new_xfers", 32'(xfer_cnt), 32'd3);

    // Continuous single-beat packets across pointer wrap
    clear_stats();
    m_tready = 1'b1;
    for (int i = 0; i < 64; i++) send_pkt(1, 1'b1, '0);
    wait_drain("wrap_drain");
    check("wrap_in_stalls", 32'(stall_cnt), 32'd0);
    check("wrap_xfers", 32'(xfer_cnt), 32'd64);
    check("wrap_consecutive", 32'(last_xfer - first_xfer), 32'd63);
    check("wrap_max_pkt_le3", 32'(max_pkt <= 3), 32'd1);
    check("wrap_pkt_count_end", 32'(pkt_count), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
